// File: rtl/wave_disp.sv
`default_nettype none
//============================================================================
// Module   : wave_disp
// Brief    : Scrolling oscilloscope-style waveform plot with grid overlay,
//            frame-synchronous snapshot and hold, RGB888 pixel output.
// Revision : 1.0 - initial release
//============================================================================
module wave_disp #(
    parameter int          WAVE_W  = 480,
    parameter int          X0      = 0,
    parameter int          Y0      = 8,
    parameter logic [23:0] C_BG    = 24'h000000,
    parameter logic [23:0] C_GRID  = 24'h404040,
    parameter logic [23:0] C_TRACE = 24'h00FF00
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [10:0] h_disp,
    input  logic [10:0] v_disp,
    input  logic        sample_valid,
    input  logic [7:0]  sample_data,
    input  logic        hold,
    output logic [23:0] pixel_data
);

    localparam int                 c_ptr_w = $clog2(WAVE_W);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(WAVE_W - 1);

    logic [7:0]         r_buf [WAVE_W];
    logic [WAVE_W-1:0]  r_valid;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_disp_ptr;
    logic               r_snap;
    logic [8:0]         r_prev_h;
    logic               r_prev_vld;
    logic [23:0]        r_pixel;

    logic [11:0]        w_dx;
    logic [11:0]        w_dy;
    logic               w_in_region;
    logic               w_frame_end;
    logic [c_ptr_w:0]   w_sum;
    logic [c_ptr_w-1:0] w_idx;
    logic               w_cur_vld;
    logic [8:0]         w_h;
    logic [8:0]         w_ph;
    logic [8:0]         w_lo;
    logic [8:0]         w_hi;
    logic               w_trace;
    logic               w_grid;

    assign pixel_data = r_pixel;

    always_comb begin
        // Offsets are taken in 12 bits so a coordinate left of / above the
        // plot shows up as a set sign bit instead of a wrapped column.
        w_dx        = {1'b0, pixel_xpos} - 12'(X0);
        w_dy        = {1'b0, pixel_ypos} - 12'(Y0);
        w_in_region = !w_dx[11] && (w_dx < 12'(WAVE_W)) &&
                      !w_dy[11] && (w_dy < 12'd256) &&
                      ((pixel_xpos != 11'd0) || (pixel_ypos != 11'd0));
        w_frame_end = (pixel_xpos == (h_disp - 11'd1)) && (pixel_ypos == v_disp);

        w_sum = {1'b0, r_disp_ptr} + {1'b0, w_dx[c_ptr_w-1:0]};
        w_idx = '0;
        if (w_in_region) begin
            w_idx = (w_sum >= (c_ptr_w + 1)'(WAVE_W)) ?
                    c_ptr_w'(w_sum - (c_ptr_w + 1)'(WAVE_W)) : w_sum[c_ptr_w-1:0];
        end

        w_cur_vld = r_valid[w_idx];
        w_h       = 9'd255 - {1'b0, r_buf[w_idx]};
        // No segment into the first column or from a column with no sample.
        w_ph      = ((w_dx == 12'd0) || !r_prev_vld) ? w_h : r_prev_h;
        w_lo      = (w_h < w_ph) ? w_h : w_ph;
        w_hi      = (w_h < w_ph) ? w_ph : w_h;

        w_trace = w_in_region && w_cur_vld &&
                  (w_dy[8:0] >= w_lo) && (w_dy[8:0] <= w_hi);
        w_grid  = w_in_region && ((w_dx[4:0] == 5'd0) || (w_dy[4:0] == 5'd0));
    end

    always_ff @(posedge lcd_pclk) begin
        if (sample_valid) begin
            r_buf[r_wr_ptr] <= sample_data;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_wr_ptr   <= '0;
            r_disp_ptr <= '0;
            r_snap     <= 1'b0;
            r_prev_h   <= 9'd0;
            r_prev_vld <= 1'b0;
            r_pixel    <= C_BG;
        end else begin
            if (sample_valid) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end

            // The snapshot sees the pointer before any same-cycle write.
            r_snap <= w_frame_end;
            if (r_snap && !hold) begin
                r_disp_ptr <= r_wr_ptr;
            end

            if (w_in_region) begin
                r_prev_h   <= w_h;
                r_prev_vld <= w_cur_vld;
            end

            if (w_trace) begin
                r_pixel <= C_TRACE;
            end else if (w_grid) begin
                r_pixel <= C_GRID;
            end else begin
                r_pixel <= C_BG;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_disp.sv
`default_nettype none
//============================================================================
// Module   : tb_wave_disp
// Brief    : Directed self-checking bench for wave_disp (480x272 panel).
// Revision : 1.0 - initial release
//============================================================================
module tb_wave_disp;

    localparam int          W     = 480;
    localparam int          Y0    = 8;
    localparam logic [23:0] BG    = 24'h000000;
    localparam logic [23:0] GRID  = 24'h404040;
    localparam logic [23:0] TRACE = 24'h00FF00;

    logic        lcd_pclk     = 1'b0;
    logic        rst_n        = 1'b0;
    logic [10:0] pixel_xpos   = 11'd0;
    logic [10:0] pixel_ypos   = 11'd0;
    logic [10:0] h_disp       = 11'd480;
    logic [10:0] v_disp       = 11'd272;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data  = 8'd0;
    logic        hold         = 1'b0;
    logic [23:0] pixel_data;

    wave_disp #(
        .WAVE_W (W),
        .X0     (0),
        .Y0     (Y0),
        .C_BG   (BG),
        .C_GRID (GRID),
        .C_TRACE(TRACE)
    ) dut (
        .lcd_pclk    (lcd_pclk),
        .rst_n       (rst_n),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .h_disp      (h_disp),
        .v_disp      (v_disp),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .hold        (hold),
        .pixel_data  (pixel_data)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] line_buf [W];
    logic [23:0] ref_a [W];
    logic [23:0] ref_b [W];
    int          m_buf [W];
    bit          m_vld [W];
    int          m_wr  = 0;
    int          m_dp  = 0;
    int          first_bad;

    // Reference colour of plot pixel (col,row) from the bench's own sample image.
    function automatic logic [23:0] exp_px(input int col, input int row);
        int idx, pidx, h, ph, lo, hi;
        idx  = (m_dp + col) % W;
        pidx = (idx + W - 1) % W;
        if (m_vld[idx]) begin
            h  = 255 - m_buf[idx];
            ph = (col > 0 && m_vld[pidx]) ? 255 - m_buf[pidx] : h;
            lo = (h < ph) ? h : ph;
            hi = (h < ph) ? ph : h;
            if (row >= lo && row <= hi) return TRACE;
        end
        if (col % 32 == 0 || row % 32 == 0) return GRID;
        return BG;
    endfunction

    function automatic int row_diff(input int row);
        int n = 0;
        first_bad = -1;
        for (int c = 0; c < W; c++) begin
            if (line_buf[c] !== exp_px(c, row)) begin
                n++;
                if (first_bad < 0) first_bad = c;
            end
        end
        return n;
    endfunction

    function automatic int trace_count(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (line_buf[c] === TRACE) n++;
        return n;
    endfunction

    function automatic int trace_cols_diff(input int cols[$]);
        int n = 0;
        bit e;
        for (int c = 0; c < W; c++) begin
            e = 1'b0;
            foreach (cols[j]) if (cols[j] == c) e = 1'b1;
            if ((line_buf[c] === TRACE) != e) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) m_vld[i] = 1'b0;
        m_wr = 0;
        m_dp = 0;
    endtask

    // mode 0: constant base, 1: alternating 0/255, 2: ramp (base+k) mod 256
    task automatic write_run(input int n, input int mode, input int base);
        int v;
        for (int k = 0; k < n; k++) begin
            @(negedge lcd_pclk);
            v = (mode == 0) ? base : (mode == 1) ? ((k % 2) ? 255 : 0) : (base + k) % 256;
            sample_valid = 1'b1;
            sample_data  = v[7:0];
            m_buf[m_wr]  = v;
            m_vld[m_wr]  = 1'b1;
            m_wr         = (m_wr + 1) % W;
        end
        @(negedge lcd_pclk);
        sample_valid = 1'b0;
    endtask

    task automatic frame_end();
        @(negedge lcd_pclk);
        pixel_xpos = h_disp - 11'd1;
        pixel_ypos = v_disp;
        @(negedge lcd_pclk);
        pixel_xpos = 11'd0;
        pixel_ypos = 11'd0;
        if (!hold) m_dp = m_wr;
        @(negedge lcd_pclk);
    endtask

    task automatic scan_row(input int row);
        for (int c = 0; c <= W; c++) begin
            @(negedge lcd_pclk);
            if (c > 0) line_buf[c-1] = pixel_data;
            if (c < W) begin
                pixel_xpos = 11'(c);
                pixel_ypos = 11'(Y0 + row);
            end else begin
                pixel_xpos = 11'd0;
                pixel_ypos = 11'd0;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n      = 1'b0;
        pixel_xpos = 11'd32;
        pixel_ypos = 11'(Y0 + 5);
        repeat (3) @(negedge lcd_pclk);
        total++;
        if (pixel_data !== BG) begin
            bad++;
            $display("FAIL reset_bg: got %h want %h", pixel_data, BG);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge lcd_pclk);
        total++;
        if (pixel_data !== GRID) begin
            bad++;
            $display("FAIL grid_px_32_5: got %h want %h", pixel_data, GRID);
        end
        pixel_xpos = 11'd5;
        @(negedge lcd_pclk);
        total++;
        if (pixel_data !== BG) begin
            bad++;
            $display("FAIL bg_px_5_5: got %h want %h", pixel_data, BG);
        end
        frame_end();
        foreach (ref_a[i]) ref_a[i] = '0;
        for (int r = 0; r < 256; r += 127) begin
            scan_row(r);
            n = trace_count(0, W - 1);
            total++;
            if (n !== 0) begin
                bad++;
                $display("FAIL empty_row%0d_trace: got %0d trace px want 0", r, n);
            end
            n = row_diff(r);
            total++;
            if (n !== 0) begin
                bad++;
                $display("FAIL empty_row%0d: %0d px differ, first col %0d got %h want %h",
                         r, n, first_bad, line_buf[first_bad], exp_px(first_bad, r));
            end
        end
    endtask

    task automatic test_partial();
        int n;
        write_run(10, 0, 50);
        scan_row(205);
        n = trace_count(0, 9);
        total++;
        if (n !== 10) begin
            bad++;
            $display("FAIL partial_cols0_9: got %0d trace px want 10", n);
        end
        n = trace_count(10, W - 1);
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL partial_cols10_479: got %0d trace px want 0", n);
        end
        scan_row(204);
        n = trace_count(0, W - 1);
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL partial_row204: got %0d trace px want 0", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        write_run(W, 0, 128);
        frame_end();
        scan_row(127);
        n = trace_count(0, W - 1);
        total++;
        if (n !== W) begin
            bad++;
            $display("FAIL flat_row127: got %0d trace px want %0d", n, W);
        end
        scan_row(126);
        n = row_diff(126);
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL flat_row126: %0d px differ, first col %0d got %h want %h",
                     n, first_bad, line_buf[first_bad], exp_px(first_bad, 126));
        end
    endtask

    task automatic test_alternate();
        int n;
        write_run(W, 1, 0);
        frame_end();
        for (int r = 0; r < 256; r += 85) begin
            scan_row(r);
            n = trace_count(1, W - 1);
            total++;
            if (n !== W - 1) begin
                bad++;
                $display("FAIL alt_row%0d_cols: got %0d trace px want %0d", r, n, W - 1);
            end
            total++;
            if ((line_buf[0] === TRACE) != (r == 255)) begin
                bad++;
                $display("FAIL alt_row%0d_col0: got %h want trace=%0d", r, line_buf[0], r == 255);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        write_run(W, 2, 0);
        frame_end();
        scan_row(200);
        ref_a = line_buf;
        n = trace_cols_diff('{55, 56, 256, 311, 312});
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL ramp_row200: %0d cols differ from expected trace set", n);
        end
        scan_row(0);
        ref_b = line_buf;
        n = trace_cols_diff('{255, 256});
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL ramp_row0: %0d cols differ from expected trace set", n);
        end
        @(negedge lcd_pclk);
        hold = 1'b1;
        for (int f = 0; f < 2; f++) begin
            write_run(50, 2, 50 * f);
            frame_end();
            scan_row(200);
            n = 0;
            for (int c = 0; c < W; c++) if (line_buf[c] !== ref_a[c]) n++;
            total++;
            if (n !== 0) begin
                bad++;
                $display("FAIL hold_frame%0d_row200: got %0d px changed want 0", f, n);
            end
            scan_row(0);
            n = 0;
            for (int c = 0; c < W; c++) if (line_buf[c] !== ref_b[c]) n++;
            total++;
            if (n !== 0) begin
                bad++;
                $display("FAIL hold_frame%0d_row0: got %0d px changed want 0", f, n);
            end
        end
        hold = 1'b0;
        frame_end();
        scan_row(200);
        n = trace_cols_diff('{156, 211, 212, 380, 435, 436});
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL release_row200: %0d cols differ from expected trace set", n);
        end
        n = 0;
        for (int c = 1; c < 370; c++)
            if ((line_buf[c] === TRACE) != (ref_a[c+100] === TRACE)) n++;
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL release_shift100: got %0d cols not shifted want 0", n);
        end
        n = row_diff(200);
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL release_model: %0d px differ, first col %0d got %h want %h",
                     n, first_bad, line_buf[first_bad], exp_px(first_bad, 200));
        end
    endtask

    task automatic test_snap_reset();
        int n;
        @(negedge lcd_pclk);
        pixel_xpos = h_disp - 11'd1;
        pixel_ypos = v_disp;
        @(negedge lcd_pclk);
        pixel_xpos   = 11'd0;
        pixel_ypos   = 11'd0;
        sample_valid = 1'b1;
        sample_data  = 8'd0;
        m_dp         = m_wr;
        m_buf[m_wr]  = 0;
        m_vld[m_wr]  = 1'b1;
        m_wr         = (m_wr + 1) % W;
        @(negedge lcd_pclk);
        sample_valid = 1'b0;
        scan_row(255);
        total++;
        if (line_buf[0] !== TRACE || line_buf[W-1] === TRACE) begin
            bad++;
            $display("FAIL snap_excl_edges: got col0=%h col479=%h want col0=%h col479 not trace",
                     line_buf[0], line_buf[W-1], TRACE);
        end
        n = row_diff(255);
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL snap_excl_row255: %0d px differ, first col %0d got %h want %h",
                     n, first_bad, line_buf[first_bad], exp_px(first_bad, 255));
        end

        @(negedge lcd_pclk);
        pixel_xpos = 11'd0;
        pixel_ypos = 11'(Y0 + 255);
        @(posedge lcd_pclk);
        #2;
        total++;
        if (pixel_data !== TRACE) begin
            bad++;
            $display("FAIL pre_reset_px: got %h want %h", pixel_data, TRACE);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (pixel_data !== BG) begin
            bad++;
            $display("FAIL async_reset_px: got %h want %h", pixel_data, BG);
        end
        repeat (3) @(negedge lcd_pclk);
        total++;
        if (pixel_data !== BG) begin
            bad++;
            $display("FAIL reset_hold_px: got %h want %h", pixel_data, BG);
        end
        rst_n = 1'b1;
        model_reset();
        scan_row(255);
        n = trace_count(0, W - 1);
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL post_reset_same_frame: got %0d trace px want 0", n);
        end
        frame_end();
        for (int r = 0; r < 256; r += 255) begin
            scan_row(r);
            n = row_diff(r);
            total++;
            if (n !== 0 || trace_count(0, W - 1) !== 0) begin
                bad++;
                $display("FAIL post_reset_row%0d: got %0d px differ, %0d trace px want 0",
                         r, n, trace_count(0, W - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_partial();
        test_back_to_back();
        test_alternate();
        test_hold();
        test_snap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
